// File: rtl/cpu_pkg.sv
// Shared decode for the multi-cycle core: branch kinds, sequencer states, condition evaluation.
package cpu_pkg;

  typedef enum logic [2:0] {
    CMD_B   = 3'd0,
    CMD_BEQ = 3'd1,
    CMD_BNE = 3'd2,
    CMD_BLT = 3'd3,
    CMD_BLE = 3'd4,
    CMD_BL  = 3'd5,
    CMD_BX  = 3'd6,
    CMD_BLX = 3'd7
  } cmd_kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic taken;
    logic link_we;
    logic ras_mismatch;
  } pulse_t;

  // Unconditional kinds (B, BL, BX, BLX) fall through to pass.
  function automatic logic cond_pass(input cmd_kind_e kind, input logic n, input logic v,
                                     input logic z);
    logic pass;
    case (kind)
      CMD_BEQ: pass = z;
      CMD_BNE: pass = !z;
      CMD_BLT: pass = n ^ v;
      CMD_BLE: pass = (n ^ v) | z;
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; push at full overwrites the oldest entry and sets a sticky flag.
// Same-cycle pop+push pops first, so a BLX return check sees the entry below its own push.
module ras_stack #(
  parameter int ADDR_W    = 9,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic                           i_pop,
  input  logic [ADDR_W-1:0]              i_data,
  output logic [ADDR_W-1:0]              o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] o_count,
  output logic                           o_overflow
);
  localparam int SP_W  = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [SP_W-1:0]  SP_ONE   = SP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic              w_pop_ok;
  logic [SP_W-1:0]   w_sp_pop;
  logic [CNT_W-1:0]  w_cnt_pop;

  assign w_pop_ok  = i_pop && (r_count != '0);
  assign w_sp_pop  = w_pop_ok ? (r_sp - SP_ONE) : r_sp;
  assign w_cnt_pop = w_pop_ok ? (r_count - CNT_ONE) : r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      r_sp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_push) begin
      r_mem[w_sp_pop] <= i_data;
      r_sp            <= w_sp_pop + SP_ONE;
      if (w_cnt_pop == CNT_FULL) begin
        r_count    <= CNT_FULL;
        r_overflow <= 1'b1;
      end else begin
        r_count <= w_cnt_pop + CNT_ONE;
      end
    end else begin
      r_sp    <= w_sp_pop;
      r_count <= w_cnt_pop;
    end
  end

  assign o_top      = r_mem[r_sp - SP_ONE];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/pc_sequencer.sv
// PC register, RUN/HALT control and branch resolution with return-address checking.
// Latency 1: PC and taken/link/mismatch pulses update on the accepting edge; cmd_ready is 0 in HALT.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 9,
  parameter int                OFF_W     = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pc_inc,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [2:0]        i_cmd_kind,
  input  logic [OFF_W-1:0]  i_offset,
  input  logic [ADDR_W-1:0] i_target,
  input  logic              i_n_flag,
  input  logic              i_v_flag,
  input  logic              i_z_flag,
  input  logic              i_halt_req,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_link_we,
  output logic [ADDR_W-1:0] o_link_addr,
  output logic              o_taken,
  output logic              o_ras_mismatch,
  output logic              o_ras_overflow,
  output logic              o_halted
);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);
  localparam int                CNT_W  = $clog2(RAS_DEPTH + 1);

  seq_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_link_addr, w_link_addr_nxt;
  pulse_t            r_pulse, w_pulse_nxt;

  cmd_kind_e         w_kind;
  logic              w_cond, w_is_ret, w_is_link;
  logic              w_push, w_pop;
  logic [ADDR_W-1:0] w_rel_target, w_ras_top;
  logic [CNT_W-1:0]  w_ras_count;
  logic              w_ras_overflow;

  assign w_kind       = cmd_kind_e'(i_cmd_kind);
  assign w_cond       = cond_pass(w_kind, i_n_flag, i_v_flag, i_z_flag);
  assign w_is_ret     = (w_kind == CMD_BX) || (w_kind == CMD_BLX);
  assign w_is_link    = (w_kind == CMD_BL) || (w_kind == CMD_BLX);
  assign w_rel_target = r_pc + {{(ADDR_W-OFF_W){i_offset[OFF_W-1]}}, i_offset};

  // halt_req outranks any command or step presented on the same edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_link_addr_nxt = r_link_addr;
    w_pulse_nxt     = '0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    if (r_state == ST_RUN) begin
      if (i_halt_req) begin
        w_state_nxt = ST_HALT;
      end else if (i_cmd_valid) begin
        if (w_is_ret) begin
          w_pc_nxt                 = i_target;
          w_pulse_nxt.taken        = 1'b1;
          w_pop                    = 1'b1;
          w_pulse_nxt.ras_mismatch = (w_ras_count == '0) || (w_ras_top != i_target);
        end else if (w_cond) begin
          w_pc_nxt          = w_rel_target;
          w_pulse_nxt.taken = 1'b1;
        end else begin
          w_pc_nxt = r_pc + PC_ONE;
        end
        if (w_is_link) begin
          w_pulse_nxt.link_we = 1'b1;
          w_link_addr_nxt     = r_pc;
          w_push              = 1'b1;
        end
      end else if (i_pc_inc) begin
        w_pc_nxt = r_pc + PC_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_PC;
      r_link_addr <= '0;
      r_pulse     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_link_addr <= w_link_addr_nxt;
      r_pulse     <= w_pulse_nxt;
    end
  end

  ras_stack #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_data     (r_pc),
    .o_top      (w_ras_top),
    .o_count    (w_ras_count),
    .o_overflow (w_ras_overflow)
  );

  assign o_cmd_ready    = (r_state == ST_RUN);
  assign o_halted       = (r_state == ST_HALT);
  assign o_pc           = r_pc;
  assign o_link_addr    = r_link_addr;
  assign o_link_we      = r_pulse.link_we;
  assign o_taken        = r_pulse.taken;
  assign o_ras_mismatch = r_pulse.ras_mismatch;
  assign o_ras_overflow = w_ras_overflow;

endmodule
